if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC and drives a handshaked instruction-memory port.
- Presents fetched words to decode through the IF/ID pipeline register.
- Absorbs decode stalls with a 1-entry skid buffer, and applies branch/jump redirects from later stages, including discarding a stale in-flight fetch.

---
 rtl/if_fetch_stage.sv | 175 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a handshaked instruction-memory
// port, feeds decode through the IF/ID register with a 1-entry skid buffer and
// handles branch/jump redirects, including squashing a stale in-flight fetch.
module if_fetch_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned PC_STEP   = 4
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [31:0] startPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        START   = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } fetch_word_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_next;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] target_next;
    fetch_word_t     skid;
    fetch_word_t     skid_next;
    logic            skid_valid;
    logic            skid_valid_next;
    fetch_word_t     ifid;
    fetch_word_t     ifid_next;
    logic            ifid_valid;
    logic            ifid_valid_next;
    logic            req;
    logic            req_next;

    logic            accept;
    logic            pending;
    logic [XLEN-1:0] pc_inc;

    assign accept  = req && imem_ready;
    assign pending = req && !imem_ready;
    assign pc_inc  = fetch_pc + XLEN'(PC_STEP);

    assign imem_req    = req;
    assign imem_addr   = fetch_pc;
    assign if_id_valid = ifid_valid;
    assign if_id_instr = ifid.instr;
    assign if_id_pc4   = ifid.pc4;

    // State register
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= START;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a redirect against an outstanding access must wait it out
    always_comb begin
        state_next = state;
        case (state)
            START:   state_next = FETCH;
            FETCH:   if (redirect && pending) state_next = DISCARD;
            DISCARD: if (accept) state_next = FETCH;
            default: state_next = START;
        endcase
    end

    // Datapath next values: PC, redirect target, skid buffer, IF/ID, request
    always_comb begin
        fetch_pc_next   = fetch_pc;
        target_next     = target;
        skid_next       = skid;
        skid_valid_next = skid_valid;
        ifid_next       = ifid;
        ifid_valid_next = ifid_valid;

        case (state)
            START: begin
                fetch_pc_next = startPC;
            end
            FETCH: begin
                if (redirect) begin
                    ifid_valid_next = 1'b0;
                    ifid_next.instr = NOP_INSTR;
                    skid_valid_next = 1'b0;
                    if (pending) begin
                        target_next = redirect_pc;
                    end else begin
                        fetch_pc_next = redirect_pc;
                    end
                end else begin
                    if (accept) begin
                        fetch_pc_next = pc_inc;
                    end
                    if (stall) begin
                        if (accept) begin
                            skid_next.instr = imem_data;
                            skid_next.pc4   = pc_inc;
                            skid_valid_next = 1'b1;
                        end
                    end else if (skid_valid) begin
                        ifid_valid_next = 1'b1;
                        ifid_next       = skid;
                        skid_valid_next = 1'b0;
                    end else if (accept) begin
                        ifid_valid_next = 1'b1;
                        ifid_next.instr = imem_data;
                        ifid_next.pc4   = pc_inc;
                    end else begin
                        ifid_valid_next = 1'b0;
                        ifid_next.instr = NOP_INSTR;
                    end
                end
            end
            DISCARD: begin
                ifid_valid_next = 1'b0;
                ifid_next.instr = NOP_INSTR;
                skid_valid_next = 1'b0;
                if (redirect) begin
                    target_next = redirect_pc;
                end
                if (accept) begin
                    fetch_pc_next = redirect ? redirect_pc : target;
                end
            end
            default: begin
                fetch_pc_next = fetch_pc;
            end
        endcase

        req_next = ((state_next == FETCH) && !skid_valid_next) || (state_next == DISCARD);
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            fetch_pc   <= '0;
            target     <= '0;
            skid       <= '0;
            skid_valid <= 1'b0;
            ifid.instr <= NOP_INSTR;
            ifid.pc4   <= '0;
            ifid_valid <= 1'b0;
            req        <= 1'b0;
        end else begin
            fetch_pc   <= fetch_pc_next;
            target     <= target_next;
            skid       <= skid_next;
            skid_valid <= skid_valid_next;
            ifid       <= ifid_next;
            ifid_valid <= ifid_valid_next;
            req        <= req_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: memory model returns an address-derived word,
// decode consumption is compared against a queue of expected instructions.
module tb_if_fetch_stage;

    logic        CLK;
    logic        Reset_L;
    logic [31:0] startPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    if_fetch_stage #(
        .NOP_INSTR(32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .startPC    (startPC),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_ready (imem_ready),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr),
        .if_id_pc4  (if_id_pc4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_data = word_at(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.instr = word_at(a);
        e.pc4   = a + 32'd4;
        sb.push_back(e);
    endtask

    task automatic check_port(input string tag, input logic r, input logic [31:0] a);
        check_eq({tag, "_req"}, 32'(imem_req), 32'(r));
        check_eq({tag, "_addr"}, imem_addr, a);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_req"}, 32'(imem_req), 32'd0);
        check_eq({tag, "_addr"}, imem_addr, 32'd0);
        check_eq({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        check_eq({tag, "_instr"}, if_id_instr, 32'h0000_0000);
        check_eq({tag, "_pc4"}, if_id_pc4, 32'd0);
    endtask

    // Decode consumes IF/ID on an edge where it is live, not stalled, not flushed
    task automatic tick();
        exp_t e;
        if (Reset_L && if_id_valid && !stall && !redirect) begin
            check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("sb_instr", if_id_instr, e.instr);
                check_eq("sb_pc4", if_id_pc4, e.pc4);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset_L     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ready  = 1'b1;
        startPC     = 32'h0040_0000;
        #1;
        check_reset("rst0");
        tick();
        tick();

        // Straight-line fetch after reset release
        push_exp(32'h0040_0000);
        push_exp(32'h0040_0004);
        Reset_L = 1'b1;
        check_eq("start_req", 32'(imem_req), 32'd0);
        tick();
        check_port("f0", 1'b1, 32'h0040_0000);
        check_eq("f0_valid", 32'(if_id_valid), 32'd0);
        tick();
        check_port("f1", 1'b1, 32'h0040_0004);
        check_eq("f1_valid", 32'(if_id_valid), 32'd1);
        check_eq("f1_pc4", if_id_pc4, 32'h0040_0004);
        check_eq("f1_instr", if_id_instr, word_at(32'h0040_0000));
        tick();
        check_port("f2", 1'b1, 32'h0040_0008);
        check_eq("f2_pc4", if_id_pc4, 32'h0040_0008);
        tick();

        // Decode stall with skid capture
        push_exp(32'h0000_00F8);
        push_exp(32'h0000_00FC);
        push_exp(32'h0000_0100);
        push_exp(32'h0000_0104);
        redirect = 1'b1;
        redirect_pc = 32'h0000_00F8;
        tick();
        redirect = 1'b0;
        check_eq("rd_valid", 32'(if_id_valid), 32'd0);
        check_port("rd", 1'b1, 32'h0000_00F8);
        tick();
        tick();
        check_port("pre_stall", 1'b1, 32'h0000_0100);
        stall = 1'b1;
        tick();
        check_port("stall0", 1'b0, 32'h0000_0104);
        check_eq("stall0_valid", 32'(if_id_valid), 32'd1);
        check_eq("stall0_pc4", if_id_pc4, 32'h0000_0100);
        check_eq("stall0_instr", if_id_instr, word_at(32'h0000_00FC));
        tick();
        tick();
        check_eq("stall2_req", 32'(imem_req), 32'd0);
        check_eq("stall2_pc4", if_id_pc4, 32'h0000_0100);
        stall = 1'b0;
        tick();
        check_port("unstall", 1'b1, 32'h0000_0104);
        check_eq("unstall_pc4", if_id_pc4, 32'h0000_0104);
        check_eq("unstall_instr", if_id_instr, word_at(32'h0000_0100));
        tick();
        check_eq("post_pc4", if_id_pc4, 32'h0000_0108);
        tick();

        // Memory wait states
        push_exp(32'h0000_0200);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        imem_ready = 1'b0;
        tick();
        check_port("wait0", 1'b1, 32'h0000_0200);
        check_eq("wait0_valid", 32'(if_id_valid), 32'd0);
        tick();
        check_port("wait1", 1'b1, 32'h0000_0200);
        check_eq("wait1_valid", 32'(if_id_valid), 32'd0);
        imem_ready = 1'b1;
        tick();
        check_eq("ready_valid", 32'(if_id_valid), 32'd1);
        check_eq("ready_instr", if_id_instr, word_at(32'h0000_0200));
        check_eq("ready_pc4", if_id_pc4, 32'h0000_0204);
        tick();

        // Redirect against a pending access
        redirect = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        imem_ready = 1'b0;
        tick();
        check_port("pend", 1'b1, 32'h0000_0300);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0800;
        tick();
        redirect = 1'b0;
        check_port("disc0", 1'b1, 32'h0000_0300);
        check_eq("disc0_valid", 32'(if_id_valid), 32'd0);
        tick();
        check_port("disc1", 1'b1, 32'h0000_0300);
        check_eq("disc1_valid", 32'(if_id_valid), 32'd0);
        imem_ready = 1'b1;
        tick();
        check_port("disc_done", 1'b1, 32'h0000_0800);
        check_eq("disc_done_valid", 32'(if_id_valid), 32'd0);
        tick();
        check_eq("tgt_valid", 32'(if_id_valid), 32'd1);
        check_eq("tgt_pc4", if_id_pc4, 32'h0000_0804);
        check_eq("tgt_instr", if_id_instr, word_at(32'h0000_0800));

        // Redirect together with stall while skid is occupied
        push_exp(32'h0000_0A00);
        push_exp(32'h0000_0A04);
        stall = 1'b1;
        tick();
        check_eq("skid_req", 32'(imem_req), 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0A00;
        tick();
        check_port("rs", 1'b1, 32'h0000_0A00);
        check_eq("rs_valid", 32'(if_id_valid), 32'd0);
        check_eq("rs_instr", if_id_instr, 32'h0000_0000);
        redirect = 1'b0;
        stall = 1'b0;
        tick();
        check_eq("rs_next_pc4", if_id_pc4, 32'h0000_0A04);
        tick();
        check_eq("rs_next2_pc4", if_id_pc4, 32'h0000_0A08);

        // Asynchronous reset mid-wait, then restart near the top of memory
        push_exp(32'hFFFF_FFF8);
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        imem_ready = 1'b0;
        tick();
        #2;
        Reset_L = 1'b0;
        startPC = 32'hFFFF_FFF8;
        #1;
        check_reset("rst1");
        imem_ready = 1'b1;
        tick();
        Reset_L = 1'b1;
        check_eq("restart_req", 32'(imem_req), 32'd0);
        tick();
        check_port("restart", 1'b1, 32'hFFFF_FFF8);
        tick();
        check_port("top", 1'b1, 32'hFFFF_FFFC);
        check_eq("top_pc4", if_id_pc4, 32'hFFFF_FFFC);
        tick();
        check_port("wrap", 1'b1, 32'h0000_0000);
        check_eq("wrap_pc4", if_id_pc4, 32'h0000_0000);
        tick();
        check_eq("wrap_next_pc4", if_id_pc4, 32'h0000_0004);
        tick();
        stall = 1'b1;
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
